// File: rtl/shift_arbiter_if.sv
// Request/result bus of the shared shift arbiter: two requester channels plus one result channel.
interface shift_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_in;
    logic [3:0]  req0_cnt;
    logic [1:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_in;
    logic [3:0]  req1_cnt;
    logic [1:0]  req1_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_id;

    // Handshake rule on every channel: a transfer happens on the rising edge where valid & ready are both 1;
    // the source holds valid and payload stable until that edge, and ready never depends on payload.
    modport master (
        output req0_valid, req0_in, req0_cnt, req0_op,
        output req1_valid, req1_in, req1_cnt, req1_op,
        output out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req0_valid, req0_in, req0_cnt, req0_op,
        input  req1_valid, req1_in, req1_cnt, req1_op,
        input  out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/shift_arbiter.sv
// Two-client round-robin arbiter sharing one 16-bit ROL/SLL/ROR/SRL shifter with a one-entry result register.
// Optional grant/contention counters are built when SHIFT_ARB_STATS_EN is defined.
module shift_arbiter (
    input  logic            clk,
    input  logic            rst_n,
    shift_arbiter_if.slave  bus,
    output logic            dbg_state,
    output logic            dbg_prio
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [15:0]     stat_grant0,
    output logic [15:0]     stat_grant1,
    output logic [15:0]     stat_conflict
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]  state;
    logic        prio;
    logic [15:0] data_q;
    logic        id_q;

    logic        slot_free;
    logic        grant0;
    logic        grant1;
    logic        accept0;
    logic        accept1;
    logic        accept;
    logic [15:0] sel_in;
    logic [3:0]  sel_cnt;
    logic [1:0]  sel_op;
    logic [15:0] result;

    function automatic logic [15:0] shift16(input logic [15:0] x, input logic [3:0] c,
                                            input logic [1:0] op);
        logic [31:0] t;
        t = 32'h0;
        shift16 = x;
        case (op)
            2'b00: begin t = {x, x} << c; shift16 = t[31:16]; end
            2'b01: shift16 = x << c;
            2'b10: begin t = {x, x} >> c; shift16 = t[15:0]; end
            default: shift16 = x >> c;
        endcase
    endfunction

    // Readies depend only on valids, prio and output-slot occupancy; payload never reaches them.
    assign slot_free = (state == ST_EMPTY) | bus.out_ready;
    assign grant0    = bus.req0_valid & (!bus.req1_valid | !prio);
    assign grant1    = bus.req1_valid & (!bus.req0_valid | prio);

    assign bus.req0_ready = grant0 & slot_free & rst_n;
    assign bus.req1_ready = grant1 & slot_free & rst_n;

    assign accept0 = bus.req0_valid & bus.req0_ready;
    assign accept1 = bus.req1_valid & bus.req1_ready;
    assign accept  = accept0 | accept1;

    assign sel_in  = grant1 ? bus.req1_in  : bus.req0_in;
    assign sel_cnt = grant1 ? bus.req1_cnt : bus.req0_cnt;
    assign sel_op  = grant1 ? bus.req1_op  : bus.req0_op;
    assign result  = shift16(sel_in, sel_cnt, sel_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            prio   <= 1'b0;
            data_q <= 16'h0000;
            id_q   <= 1'b0;
        end else if (accept) begin
            // A new result may replace an old one in the same edge it drains.
            state  <= ST_FULL;
            data_q <= result;
            id_q   <= accept1;
            prio   <= ~accept1;
        end else if ((state == ST_FULL) && bus.out_ready) begin
            state  <= ST_EMPTY;
        end
    end

    assign bus.out_valid = (state == ST_FULL);
    assign bus.out_data  = data_q;
    assign bus.out_id    = id_q;
    assign dbg_state     = state;
    assign dbg_prio      = prio;

`ifdef SHIFT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0   <= 16'h0000;
            stat_grant1   <= 16'h0000;
            stat_conflict <= 16'h0000;
        end else begin
            if (accept0 && (stat_grant0 != 16'hFFFF))
                stat_grant0 <= stat_grant0 + 16'h0001;
            if (accept1 && (stat_grant1 != 16'hFFFF))
                stat_grant1 <= stat_grant1 + 16'h0001;
            if (accept && bus.req0_valid && bus.req1_valid && (stat_conflict != 16'hFFFF))
                stat_conflict <= stat_conflict + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, arbitration order, stall/drain, shifter corners, async reset.
module tb_shift_arbiter;
    logic clk;
    logic rst_n;
    logic dbg_state;
    logic dbg_prio;
`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] stat_grant0;
    logic [15:0] stat_grant1;
    logic [15:0] stat_conflict;
`endif

    int checks   = 0;
    int failures = 0;

    shift_arbiter_if bus ();

    shift_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state),
        .dbg_prio  (dbg_prio)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .stat_grant0   (stat_grant0),
        .stat_grant1   (stat_grant1),
        .stat_conflict (stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req0(input logic v, input logic [15:0] d, input logic [3:0] c, input logic [1:0] op);
        bus.req0_valid = v;
        bus.req0_in    = d;
        bus.req0_cnt   = c;
        bus.req0_op    = op;
    endtask

    task automatic set_req1(input logic v, input logic [15:0] d, input logic [3:0] c, input logic [1:0] op);
        bus.req1_valid = v;
        bus.req1_in    = d;
        bus.req1_cnt   = c;
        bus.req1_op    = op;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic id);
        chk({tag, "_valid"}, {15'h0, bus.out_valid}, {15'h0, v});
        chk({tag, "_data"}, bus.out_data, d);
        chk({tag, "_id"}, {15'h0, bus.out_id}, {15'h0, id});
    endtask

    task automatic chk_ready(input string tag, input logic r0, input logic r1);
        chk({tag, "_ready0"}, {15'h0, bus.req0_ready}, {15'h0, r0});
        chk({tag, "_ready1"}, {15'h0, bus.req1_ready}, {15'h0, r1});
    endtask

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    initial begin
        logic [15:0] dual_data [4];
        logic        dual_id   [4];
        dual_data[0] = 16'h0FF0; dual_id[0] = 1'b0;
        dual_data[1] = 16'h00F0; dual_id[1] = 1'b1;
        dual_data[2] = 16'h0FF0; dual_id[2] = 1'b0;
        dual_data[3] = 16'h00F0; dual_id[3] = 1'b1;

        // Reset with a request already pending: nothing may be accepted
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        set_req0(1'b1, 16'h1111, 4'd1, OP_SLL);
        set_req1(1'b0, 16'h0000, 4'd0, OP_ROL);
        #1;
        chk_out("reset", 1'b0, 16'h0000, 1'b0);
        chk_ready("reset", 1'b0, 1'b0);
        chk("reset_prio", {15'h0, dbg_prio}, 16'h0000);
        tick();
        tick();
        chk_out("reset_held", 1'b0, 16'h0000, 1'b0);
        set_req0(1'b0, 16'h0000, 4'd0, OP_ROL);
        rst_n = 1'b1;
        tick();
        chk_out("post_reset", 1'b0, 16'h0000, 1'b0);

        // Single ROL request, one-cycle latency
        bus.out_ready = 1'b1;
        set_req0(1'b1, 16'h8001, 4'd1, OP_ROL);
        #1;
        chk_ready("rol1", 1'b1, 1'b0);
        tick();
        set_req0(1'b0, 16'h0000, 4'd0, OP_ROL);
        chk_out("rol1", 1'b1, 16'h0003, 1'b0);
        chk("rol1_prio", {15'h0, dbg_prio}, 16'h0001);
        tick();
        chk_out("drain", 1'b0, 16'h0003, 1'b0);

        // Solo req1 brings priority back to client 0
        set_req1(1'b1, 16'hF000, 4'd8, OP_SRL);
        #1;
        chk_ready("solo1", 1'b0, 1'b1);
        tick();
        set_req1(1'b0, 16'h0000, 4'd0, OP_ROL);
        chk_out("solo1", 1'b1, 16'h00F0, 1'b1);

        // Continuous dual requests alternate 0,1,0,1 at full throughput
        set_req0(1'b1, 16'h00FF, 4'd4, OP_SLL);
        set_req1(1'b1, 16'hF000, 4'd8, OP_SRL);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_ready($sformatf("dual%0d", i), !dual_id[i], dual_id[i]);
            tick();
            chk_out($sformatf("dual%0d", i), 1'b1, dual_data[i], dual_id[i]);
        end
        set_req0(1'b0, 16'h0000, 4'd0, OP_ROL);

        // Stalled output: req1 waits, nothing moves, priority stays put
        bus.out_ready = 1'b0;
        set_req1(1'b1, 16'h1234, 4'd4, OP_ROL);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ready($sformatf("stall%0d", i), 1'b0, 1'b0);
            tick();
            chk_out($sformatf("stall%0d", i), 1'b1, 16'h00F0, 1'b1);
            chk($sformatf("stall%0d_prio", i), {15'h0, dbg_prio}, 16'h0000);
        end
        bus.out_ready = 1'b1;
        #1;
        chk_ready("unstall", 1'b0, 1'b1);
        tick();
        set_req1(1'b0, 16'h0000, 4'd0, OP_ROL);
        chk_out("unstall", 1'b1, 16'h2341, 1'b1);

        // Shifter corners, one accept per cycle from client 0
        set_req0(1'b1, 16'h0001, 4'd0, OP_ROR);
        tick();
        chk_out("ror0", 1'b1, 16'h0001, 1'b0);
        set_req0(1'b1, 16'h0001, 4'd15, OP_ROR);
        tick();
        chk_out("ror15", 1'b1, 16'h0002, 1'b0);
        set_req0(1'b1, 16'h8000, 4'd15, OP_SRL);
        tick();
        chk_out("srl15", 1'b1, 16'h0001, 1'b0);
        set_req0(1'b1, 16'h0001, 4'd15, OP_SLL);
        tick();
        chk_out("sll15", 1'b1, 16'h8000, 1'b0);
        set_req0(1'b1, 16'hF00F, 4'd0, OP_SLL);
        tick();
        chk_out("sll0", 1'b1, 16'hF00F, 1'b0);
        set_req0(1'b1, 16'hA5C3, 4'd0, OP_ROL);
        tick();
        chk_out("rol0", 1'b1, 16'hA5C3, 1'b0);
        set_req0(1'b1, 16'hA5C3, 4'd0, OP_SRL);
        tick();
        chk_out("srl0", 1'b1, 16'hA5C3, 1'b0);
        set_req0(1'b1, 16'h8001, 4'd4, OP_ROR);
        tick();
        chk_out("ror4", 1'b1, 16'h1800, 1'b0);
        set_req0(1'b0, 16'h0000, 4'd0, OP_ROL);
        bus.out_ready = 1'b0;

        // Asynchronous reset mid-transfer, away from any rising edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        set_req0(1'b1, 16'h00FF, 4'd4, OP_SLL);
        #1;
        chk_out("async_rst", 1'b0, 16'h0000, 1'b0);
        chk("async_rst_prio", {15'h0, dbg_prio}, 16'h0000);
        chk_ready("async_rst", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        set_req1(1'b1, 16'hF000, 4'd8, OP_SRL);
        #1;
        chk_ready("after_rst", 1'b1, 1'b0);
        tick();
        set_req0(1'b0, 16'h0000, 4'd0, OP_ROL);
        set_req1(1'b0, 16'h0000, 4'd0, OP_ROL);
        chk_out("after_rst", 1'b1, 16'h0FF0, 1'b0);

`ifdef SHIFT_ARB_STATS_EN
        // Counters: 3 solo req0 accepts then 2 dual cycles (grant 1 then 0)
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("stat_rst_g0", stat_grant0, 16'h0000);
        chk("stat_rst_g1", stat_grant1, 16'h0000);
        chk("stat_rst_cf", stat_conflict, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        set_req0(1'b1, 16'h0001, 4'd1, OP_SLL);
        tick();
        tick();
        tick();
        set_req1(1'b1, 16'h0004, 4'd1, OP_SRL);
        tick();
        chk_out("stat_dual0", 1'b1, 16'h0002, 1'b1);
        tick();
        chk_out("stat_dual1", 1'b1, 16'h0002, 1'b0);
        set_req0(1'b0, 16'h0000, 4'd0, OP_ROL);
        set_req1(1'b0, 16'h0000, 4'd0, OP_ROL);
        tick();
        chk("stat_g0", stat_grant0, 16'd4);
        chk("stat_g1", stat_grant1, 16'd1);
        chk("stat_cf", stat_conflict, 16'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
